// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome encoding and the branch resolver FSM state.
`include "mips_core.svh"

package mips_core_pkg;

    localparam int unsigned ADDR_WIDTH = `ADDR_WIDTH;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        StIdle     = 1'b0,
        StRedirect = 1'b1
    } resolver_state_e;

    function automatic BranchOutcome cond_to_outcome(input logic cond);
        return cond ? TAKEN : NOT_TAKEN;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage branch, predictor feedback and redirect handshake bundle for branch_resolver.
// Counter signals exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_resolver_if
    import mips_core_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) ();

    logic                  i_ex_valid;
    logic                  i_ex_is_branch;
    logic [ADDR_WIDTH-1:0] i_ex_pc;
    BranchOutcome          i_ex_prediction;
    logic                  i_ex_cond;
    logic [ADDR_WIDTH-1:0] i_ex_recovery_target;

    logic                  o_fb_valid;
    logic [ADDR_WIDTH-1:0] o_fb_pc;
    BranchOutcome          o_fb_prediction;
    BranchOutcome          o_fb_outcome;

    logic                  o_redirect_valid;
    logic [ADDR_WIDTH-1:0] o_redirect_pc;
    logic                  i_redirect_ready;
    logic                  o_busy;

    if (CNT_WIDTH < 2) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 2");
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0]  o_branch_count;
    logic [CNT_WIDTH-1:0]  o_mispredict_count;

    modport master (
        output i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_prediction, i_ex_cond,
               i_ex_recovery_target, i_redirect_ready,
        input  o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
               o_redirect_valid, o_redirect_pc, o_busy, o_branch_count, o_mispredict_count
    );

    modport slave (
        input  i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_prediction, i_ex_cond,
               i_ex_recovery_target, i_redirect_ready,
        output o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
               o_redirect_valid, o_redirect_pc, o_busy, o_branch_count, o_mispredict_count
    );
`else
    modport master (
        output i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_prediction, i_ex_cond,
               i_ex_recovery_target, i_redirect_ready,
        input  o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
               o_redirect_valid, o_redirect_pc, o_busy
    );

    modport slave (
        input  i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_prediction, i_ex_cond,
               i_ex_recovery_target, i_redirect_ready,
        output o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
               o_redirect_valid, o_redirect_pc, o_busy
    );
`endif

endinterface

// File: rtl/branch_perf_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on reset.
module branch_perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mips_core.svh
// Core-wide address width shared by the MIPS pipeline blocks.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH

`define ADDR_WIDTH 32

`endif

// File: rtl/branch_resolver.sv
// Resolves EX-stage conditional branches: 1-cycle predictor feedback plus a held redirect
// on mispredict. Optional performance counters under BRANCH_PERF_CNT_EN.
module branch_resolver
    import mips_core_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    branch_resolver_if.slave bus
);

    resolver_state_e       state_q, state_d;
    logic                  accept;
    logic                  mispredict;
    BranchOutcome          outcome;

    logic                  fb_valid_q;
    logic [ADDR_WIDTH-1:0] fb_pc_q;
    BranchOutcome          fb_pred_q;
    BranchOutcome          fb_outcome_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;

    if (CNT_WIDTH < 2) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 2");
    end

    // While a redirect is pending every EX instruction is wrong-path, so nothing is accepted.
    always_comb begin
        accept     = bus.i_ex_valid & bus.i_ex_is_branch & (state_q == StIdle);
        outcome    = cond_to_outcome(bus.i_ex_cond);
        mispredict = accept & (outcome != bus.i_ex_prediction);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (mispredict) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (bus.i_redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Feedback data only loads on acceptance so it holds between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_valid_q    <= 1'b0;
            fb_pc_q       <= '0;
            fb_pred_q     <= NOT_TAKEN;
            fb_outcome_q  <= NOT_TAKEN;
            redirect_pc_q <= '0;
        end else begin
            fb_valid_q <= accept;
            if (accept) begin
                fb_pc_q      <= bus.i_ex_pc;
                fb_pred_q    <= bus.i_ex_prediction;
                fb_outcome_q <= outcome;
            end
            if (mispredict) begin
                redirect_pc_q <= bus.i_ex_recovery_target;
            end
        end
    end

    always_comb begin
        bus.o_fb_valid       = fb_valid_q;
        bus.o_fb_pc          = fb_pc_q;
        bus.o_fb_prediction  = fb_pred_q;
        bus.o_fb_outcome     = fb_outcome_q;
        bus.o_redirect_valid = (state_q == StRedirect);
        bus.o_redirect_pc    = redirect_pc_q;
        bus.o_busy           = (state_q == StRedirect);
    end

`ifdef BRANCH_PERF_CNT_EN
    branch_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_branch_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept),
        .count(bus.o_branch_count)
    );

    branch_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_mispredict_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (mispredict),
        .count(bus.o_mispredict_count)
    );
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; counter checks compile in with
// BRANCH_PERF_CNT_EN.
module tb_branch_resolver;
    import mips_core_pkg::*;

    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [CW-1:0] exp_br;
    logic [CW-1:0] exp_mis;

    branch_resolver_if #(.CNT_WIDTH(CW)) bus_if ();

    branch_resolver #(
        .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic [ADDR_WIDTH-1:0] pc,
                          input BranchOutcome pred, input logic cond,
                          input logic [ADDR_WIDTH-1:0] rec);
        bus_if.i_ex_valid           = v;
        bus_if.i_ex_is_branch       = br;
        bus_if.i_ex_pc              = pc;
        bus_if.i_ex_prediction      = pred;
        bus_if.i_ex_cond            = cond;
        bus_if.i_ex_recovery_target = rec;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 1'b0, '0, NOT_TAKEN, 1'b0, '0);
    endtask

    // Reference counter model, saturating at all-ones.
    task automatic note_accept(input logic mis);
        if (exp_br != {CW{1'b1}}) exp_br = exp_br + 1'b1;
        if (mis && exp_mis != {CW{1'b1}}) exp_mis = exp_mis + 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_ex();
        bus_if.i_redirect_ready = 1'b0;
        step();
        step();
        exp_br  = '0;
        exp_mis = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL rst_fb_valid got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_redirect_valid got %b want 0", bus_if.o_redirect_valid); end
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", bus_if.o_busy); end
        if (bus_if.o_fb_pc !== '0) begin failures++; $display("FAIL rst_fb_pc got %h want 0", bus_if.o_fb_pc); end
        if (bus_if.o_redirect_pc !== '0) begin failures++; $display("FAIL rst_redirect_pc got %h want 0", bus_if.o_redirect_pc); end
        if (bus_if.o_fb_prediction !== NOT_TAKEN || bus_if.o_fb_outcome !== NOT_TAKEN) begin
            failures++; $display("FAIL rst_fb_pred_outcome got %b/%b want 0/0", bus_if.o_fb_prediction, bus_if.o_fb_outcome);
        end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_branch_count !== '0 || bus_if.o_mispredict_count !== '0) begin
            failures++; $display("FAIL rst_counts got %0d/%0d want 0/0", bus_if.o_branch_count, bus_if.o_mispredict_count);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_correct_not_taken();
        set_ex(1'b1, 1'b1, 32'h100, NOT_TAKEN, 1'b0, 32'h999);
        note_accept(1'b0);
        step();
        clear_ex();
        checks += 5;
        if (bus_if.o_fb_valid !== 1'b1) begin failures++; $display("FAIL nt_fb_valid got %b want 1", bus_if.o_fb_valid); end
        if (bus_if.o_fb_pc !== 32'h100) begin failures++; $display("FAIL nt_fb_pc got %h want 100", bus_if.o_fb_pc); end
        if (bus_if.o_fb_outcome !== NOT_TAKEN) begin failures++; $display("FAIL nt_fb_outcome got %b want 0", bus_if.o_fb_outcome); end
        if (bus_if.o_fb_prediction !== NOT_TAKEN) begin failures++; $display("FAIL nt_fb_pred got %b want 0", bus_if.o_fb_prediction); end
        if (bus_if.o_redirect_valid !== 1'b0 || bus_if.o_busy !== 1'b0) begin
            failures++; $display("FAIL nt_no_redirect got %b/%b want 0/0", bus_if.o_redirect_valid, bus_if.o_busy);
        end
        step();
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL nt_fb_pulse_end got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_fb_pc !== 32'h100) begin failures++; $display("FAIL nt_fb_pc_hold got %h want 100", bus_if.o_fb_pc); end
    endtask

    task automatic test_mispredict_redirect();
        bus_if.i_redirect_ready = 1'b0;
        set_ex(1'b1, 1'b1, 32'h200, NOT_TAKEN, 1'b1, 32'h240);
        note_accept(1'b1);
        step();
        clear_ex();
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b1) begin failures++; $display("FAIL mp_fb_valid got %b want 1", bus_if.o_fb_valid); end
        if (bus_if.o_fb_outcome !== TAKEN) begin failures++; $display("FAIL mp_fb_outcome got %b want 1", bus_if.o_fb_outcome); end
        for (int k = 1; k <= 4; k++) begin
            checks += 3;
            if (bus_if.o_redirect_valid !== 1'b1) begin failures++; $display("FAIL mp_redirect_valid_c%0d got %b want 1", k, bus_if.o_redirect_valid); end
            if (bus_if.o_redirect_pc !== 32'h240) begin failures++; $display("FAIL mp_redirect_pc_c%0d got %h want 240", k, bus_if.o_redirect_pc); end
            if (bus_if.o_busy !== 1'b1) begin failures++; $display("FAIL mp_busy_c%0d got %b want 1", k, bus_if.o_busy); end
            if (k > 1) begin
                checks++;
                if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL mp_fb_single_c%0d got %b want 0", k, bus_if.o_fb_valid); end
            end
            bus_if.i_redirect_ready = (k == 4);
            step();
        end
        bus_if.i_redirect_ready = 1'b0;
        checks += 2;
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL mp_idle_busy got %b want 0", bus_if.o_busy); end
        if (bus_if.o_redirect_valid !== 1'b0) begin failures++; $display("FAIL mp_idle_redirect got %b want 0", bus_if.o_redirect_valid); end
    endtask

    task automatic test_wrong_path();
        bus_if.i_redirect_ready = 1'b0;
        set_ex(1'b1, 1'b1, 32'h280, TAKEN, 1'b0, 32'h2c0);
        note_accept(1'b1);
        step();
        // Wrong-path mispredicting branch presented on the handshake cycle.
        set_ex(1'b1, 1'b1, 32'h300, NOT_TAKEN, 1'b1, 32'h340);
        bus_if.i_redirect_ready = 1'b1;
        step();
        clear_ex();
        bus_if.i_redirect_ready = 1'b0;
        checks += 3;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL wp_no_fb got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_fb_pc !== 32'h280) begin failures++; $display("FAIL wp_fb_pc got %h want 280", bus_if.o_fb_pc); end
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL wp_busy got %b want 0", bus_if.o_busy); end
        step();
        checks++;
        if (bus_if.o_redirect_valid !== 1'b0) begin failures++; $display("FAIL wp_no_redirect got %b want 0", bus_if.o_redirect_valid); end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_branch_count !== exp_br || bus_if.o_mispredict_count !== exp_mis) begin
            failures++; $display("FAIL wp_counts got %0d/%0d want %0d/%0d", bus_if.o_branch_count, bus_if.o_mispredict_count, exp_br, exp_mis);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [ADDR_WIDTH-1:0] pcs [3];
        BranchOutcome          preds [3];
        pcs   = '{32'h400, 32'h404, 32'h408};
        preds = '{TAKEN, NOT_TAKEN, TAKEN};
        do_reset();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 1'b1, pcs[i], preds[i], (preds[i] == TAKEN), 32'hdead);
            note_accept(1'b0);
            step();
            checks += 3;
            if (bus_if.o_fb_valid !== 1'b1) begin failures++; $display("FAIL b2b_fb_valid_%0d got %b want 1", i, bus_if.o_fb_valid); end
            if (bus_if.o_fb_pc !== pcs[i]) begin failures++; $display("FAIL b2b_fb_pc_%0d got %h want %h", i, bus_if.o_fb_pc, pcs[i]); end
            if (bus_if.o_fb_outcome !== preds[i]) begin failures++; $display("FAIL b2b_outcome_%0d got %b want %b", i, bus_if.o_fb_outcome, preds[i]); end
        end
        clear_ex();
        step();
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got %b want 0", bus_if.o_busy); end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_branch_count !== 4'd3 || bus_if.o_mispredict_count !== 4'd0) begin
            failures++; $display("FAIL b2b_counts got %0d/%0d want 3/0", bus_if.o_branch_count, bus_if.o_mispredict_count);
        end
`endif
    endtask

    task automatic test_jumps_and_invalid();
        set_ex(1'b1, 1'b0, 32'h500, NOT_TAKEN, 1'b1, 32'h540);
        step();
        set_ex(1'b0, 1'b1, 32'h600, NOT_TAKEN, 1'b1, 32'h640);
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL jump_no_fb got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL jump_no_redirect got %b want 0", bus_if.o_busy); end
        step();
        clear_ex();
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL invalid_no_fb got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_redirect_valid !== 1'b0) begin failures++; $display("FAIL invalid_no_redirect got %b want 0", bus_if.o_redirect_valid); end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_branch_count !== exp_br || bus_if.o_mispredict_count !== exp_mis) begin
            failures++; $display("FAIL jump_counts got %0d/%0d want %0d/%0d", bus_if.o_branch_count, bus_if.o_mispredict_count, exp_br, exp_mis);
        end
`endif
    endtask

    task automatic test_reset_in_redirect();
        bus_if.i_redirect_ready = 1'b0;
        set_ex(1'b1, 1'b1, 32'h700, TAKEN, 1'b0, 32'h780);
        step();
        clear_ex();
        checks++;
        if (bus_if.o_busy !== 1'b1) begin failures++; $display("FAIL rr_busy_before got %b want 1", bus_if.o_busy); end
        rst_n = 1'b0;
        step();
        checks += 5;
        if (bus_if.o_busy !== 1'b0 || bus_if.o_redirect_valid !== 1'b0) begin
            failures++; $display("FAIL rr_redirect_abandoned got %b/%b want 0/0", bus_if.o_busy, bus_if.o_redirect_valid);
        end
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL rr_fb_valid got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_fb_pc !== '0) begin failures++; $display("FAIL rr_fb_pc got %h want 0", bus_if.o_fb_pc); end
        if (bus_if.o_redirect_pc !== '0) begin failures++; $display("FAIL rr_redirect_pc got %h want 0", bus_if.o_redirect_pc); end
        if (bus_if.o_fb_prediction !== NOT_TAKEN || bus_if.o_fb_outcome !== NOT_TAKEN) begin
            failures++; $display("FAIL rr_fb_pred_outcome got %b/%b want 0/0", bus_if.o_fb_prediction, bus_if.o_fb_outcome);
        end
        exp_br  = '0;
        exp_mis = '0;
        rst_n = 1'b1;
        set_ex(1'b1, 1'b0, 32'h800, NOT_TAKEN, 1'b1, 32'h880);
        step();
        clear_ex();
        step();
        checks += 2;
        if (bus_if.o_fb_valid !== 1'b0) begin failures++; $display("FAIL rr_jump_no_fb got %b want 0", bus_if.o_fb_valid); end
        if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL rr_jump_no_redirect got %b want 0", bus_if.o_busy); end
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_branch_count !== '0 || bus_if.o_mispredict_count !== '0) begin
            failures++; $display("FAIL rr_counts got %0d/%0d want 0/0", bus_if.o_branch_count, bus_if.o_mispredict_count);
        end
`endif
    endtask

    task automatic test_saturation();
        bus_if.i_redirect_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_ex(1'b1, 1'b1, 32'h900 + 32'(4 * i), NOT_TAKEN, 1'b1, 32'ha00);
            note_accept(1'b1);
            step();
            clear_ex();
            checks++;
            if (bus_if.o_redirect_valid !== 1'b1 || bus_if.o_fb_valid !== 1'b1) begin
                failures++; $display("FAIL sat_redirect_%0d got %b/%b want 1/1", i, bus_if.o_redirect_valid, bus_if.o_fb_valid);
            end
            step();
            checks++;
            if (bus_if.o_busy !== 1'b0) begin failures++; $display("FAIL sat_handshake_%0d got %b want 0", i, bus_if.o_busy); end
        end
        bus_if.i_redirect_ready = 1'b0;
`ifdef BRANCH_PERF_CNT_EN
        checks++;
        if (bus_if.o_mispredict_count !== 4'd15 || bus_if.o_branch_count !== 4'd15) begin
            failures++; $display("FAIL sat_counts got %0d/%0d want 15/15", bus_if.o_branch_count, bus_if.o_mispredict_count);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_br   = '0;
        exp_mis  = '0;
        rst_n    = 1'b0;
        clear_ex();
        bus_if.i_redirect_ready = 1'b0;
        test_reset();
        test_correct_not_taken();
        test_mispredict_redirect();
        test_wrong_path();
        test_back_to_back();
        test_jumps_and_invalid();
        test_reset_in_redirect();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_ex_valid  input  1  EX stage holds a valid instruction this cycle.
REQ-005 i_ex_is_branch  input  1  the instruction is a conditional branch, not a jump.
REQ-006 i_ex_pc  input  ADDR_WIDTH  PC of the EX instruction.
REQ-007 i_ex_prediction  input  BranchOutcome  prediction made at decode.
REQ-008 i_ex_cond  input  1  branch condition evaluated true (1 = TAKEN).
REQ-009 i_ex_recovery_target  input  ADDR_WIDTH  PC to fetch if the prediction was wrong.
REQ-010 o_fb_valid / o_fb_pc / o_fb_prediction / o_fb_outcome  output  1/ADDR_WIDTH/BranchOutcome/BranchOutcome  predictor feedback bundle.
REQ-011 o_redirect_valid  output  1  misprediction redirect request to the hazard controller.
REQ-012 o_redirect_pc  output  ADDR_WIDTH  redirect fetch address.
REQ-013 i_redirect_ready  input  1  hazard controller accepts the redirect this cycle.
REQ-014 o_busy  output  1  resolver is holding a redirect; EX SHALL stall on it.
REQ-015 o_branch_count / o_mispredict_count  output  CNT_WIDTH  performance counters (present only under REQ-031).

Function
REQ-016 An EX branch SHALL be accepted only when i_ex_valid & i_ex_is_branch & state==IDLE.
REQ-017 Outcome SHALL be TAKEN if i_ex_cond=1, else NOT_TAKEN; mispredict SHALL be outcome != i_ex_prediction.
REQ-018 Feedback latency SHALL be exactly 1 cycle: o_fb_valid pulses for 1 cycle after acceptance, with pc/prediction/outcome registered from the accepting cycle.
REQ-019 o_fb_* data SHALL hold its last value when o_fb_valid=0.
REQ-020 FSM states: IDLE, REDIRECT.
REQ-021 IDLE -> REDIRECT on an accepted mispredicted branch; otherwise IDLE stays IDLE.
REQ-022 In REDIRECT, o_redirect_valid=1 and o_redirect_pc=the registered recovery target, both stable until the handshake.
REQ-023 REDIRECT -> IDLE in the cycle o_redirect_valid & i_redirect_ready; the redirect completes in that cycle.
REQ-024 o_redirect_valid SHALL first rise in the same cycle as the matching o_fb_valid pulse.
REQ-025 o_busy SHALL equal (state==REDIRECT).
REQ-026 In REDIRECT, including the handshake cycle, all EX inputs are wrong-path and SHALL be ignored: no feedback and no count.
REQ-027 Jumps (i_ex_is_branch=0) and i_ex_valid=0 cycles SHALL produce no feedback, no redirect and no count.
REQ-028 Back-to-back correctly predicted branches SHALL each produce a feedback pulse on consecutive cycles.

Reset
REQ-029 While rst_n=0: state=IDLE, o_fb_valid=0, o_redirect_valid=0, o_busy=0, o_fb_pc=0, o_redirect_pc=0, o_fb_prediction=o_fb_outcome=NOT_TAKEN, counters=0.
REQ-030 Reset asserted in REDIRECT SHALL abandon the pending redirect without a handshake.

Configuration
REQ-031 Macro BRANCH_PERF_CNT_EN defined: o_branch_count increments per accepted branch and o_mispredict_count per accepted mispredict, saturating at all-ones. Undefined: counter ports and registers are absent.

Structure
REQ-032 BranchOutcome (TAKEN/NOT_TAKEN) SHALL come from mips_core_pkg; the resolver FSM state enum SHALL be added to mips_core_pkg; ADDR_WIDTH SHALL come from mips_core.svh.
REQ-033 The counters SHALL be one sub-module, branch_perf_counter (sat-increment, CNT_WIDTH), instantiated twice under BRANCH_PERF_CNT_EN.

Verification
REQ-034 Branch pc=0x100, pred NOT_TAKEN, cond=0 -> next cycle fb_valid=1, fb_pc=0x100, outcome NOT_TAKEN; no redirect.
REQ-035 Branch pc=0x200, pred NOT_TAKEN, cond=1, recovery=0x240, ready held 0 for 3 cycles -> redirect_valid=1, redirect_pc=0x240, busy=1 for 4 cycles; idle after the handshake.
REQ-036 In REDIRECT, present a branch at pc=0x300 on the handshake cycle -> no fb pulse for 0x300; counters unchanged.
REQ-037 Three correct branches on consecutive cycles -> three consecutive fb pulses; branch_count=3, mispredict_count=0.
REQ-038 Assert reset while in REDIRECT -> next cycle all outputs at reset values; a jump (is_branch=0) then produces nothing.
REQ-039 CNT_WIDTH=4, 17 mispredicts -> mispredict_count saturates at 15.
